// File: rtl/led_pattern_pkg.sv
// Shared mode encodings, bounce direction and PWM width for the LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int PWM_W = 4;

endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and emits a registered one-cycle tick
// on the cycle after the terminal count. clr restarts the count and drops any pending tick.
module tick_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (clr) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else if (en) begin
            tick_q <= (cnt_q == LAST);
            cnt_q  <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            tick_q <= 1'b0;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern driver (static/blink/rotate/bounce) stepped by a prescaled tick.
// Define LED_PWM_EN to gate the LED outputs with a 4-bit brightness PWM.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int CLK_HZ   = 12000000,
    parameter int STEP_HZ  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [NUM_LEDS-1:0] pattern,
    input  logic [PWM_W-1:0]    bright,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);

    // mode_q      | meaning
    // MODE_STATIC | led follows pattern every cycle
    // MODE_BLINK  | phase toggles per tick, led = phase ? pattern : 0
    // MODE_ROTATE | led rotates left per tick, seeded from pattern at reload
    // MODE_BOUNCE | one-hot walks up and down, ends not repeated

    localparam int               DIV      = CLK_HZ / STEP_HZ;
    localparam int               POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

    if (DIV < 2) begin : g_div_check
        $error("led_pattern_gen: CLK_HZ/STEP_HZ must be at least 2");
    end

    mode_e               mode_q;
    logic [NUM_LEDS-1:0] led_q;
    logic                phase_q, phase_d;
    logic [POS_W-1:0]    pos_q, pos_d;
    dir_e                dir_q, dir_d;
    logic                mode_chg;
    logic                tick_w;

    assign mode_chg = (mode != mode_q);

    tick_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (mode_chg),
        .tick  (tick_w)
    );

    function automatic logic [NUM_LEDS-1:0] one_hot(input logic [POS_W-1:0] p);
        logic [NUM_LEDS-1:0] r;
        for (int i = 0; i < NUM_LEDS; i++) r[i] = (p == POS_W'(i));
        return r;
    endfunction

    function automatic logic [NUM_LEDS-1:0] rot_left(input logic [NUM_LEDS-1:0] v);
        logic [NUM_LEDS-1:0] r;
        for (int i = 0; i < NUM_LEDS; i++) r[(i + 1) % NUM_LEDS] = v[i];
        return r;
    endfunction

    always_comb begin
        phase_d = tick_w ? ~phase_q : phase_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        if (tick_w && (NUM_LEDS > 1)) begin
            if (dir_q == DIR_UP) begin
                if (pos_q == POS_LAST) begin
                    dir_d = DIR_DOWN;
                    pos_d = pos_q - POS_W'(1);
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
            end else if (pos_q == '0) begin
                dir_d = DIR_UP;
                pos_d = pos_q + POS_W'(1);
            end else begin
                pos_d = pos_q - POS_W'(1);
            end
        end
    end

    // A mode change reloads state and takes priority over a tick on the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_STATIC;
            led_q   <= '0;
            phase_q <= 1'b1;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
        end else if (mode_chg) begin
            mode_q  <= mode_e'(mode);
            phase_q <= 1'b1;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            led_q   <= (mode_e'(mode) == MODE_BOUNCE) ? one_hot('0) : pattern;
        end else begin
            case (mode_q)
                MODE_STATIC: led_q <= pattern;
                MODE_BLINK: begin
                    phase_q <= phase_d;
                    led_q   <= phase_d ? pattern : '0;
                end
                MODE_ROTATE: begin
                    if (tick_w) led_q <= rot_left(led_q);
                end
                MODE_BOUNCE: begin
                    pos_q <= pos_d;
                    dir_q <= dir_d;
                    led_q <= one_hot(pos_d);
                end
                default: led_q <= '0;
            endcase
        end
    end

    assign tick = tick_w;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= '0;
        else        pwm_q <= pwm_q + PWM_W'(1);
    end

    assign led = led_q & {NUM_LEDS{(pwm_q < bright)}};
`else
    logic bright_unused;
    assign bright_unused = ^bright;
    assign led = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen with NUM_LEDS=4, DIV=4; PWM section under LED_PWM_EN.
module tb_led_pattern_gen;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] pattern;
    logic [3:0]   bright;
    logic         tick;
    logic [N-1:0] led;

    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] exp_q[$];

    led_pattern_gen #(.NUM_LEDS(N), .CLK_HZ(8), .STEP_HZ(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .pattern (pattern),
        .bright  (bright),
        .tick    (tick),
        .led     (led)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_underflow"}, exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, {28'd0, led}, {28'd0, e});
        end
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (tick !== 1'b1 && cyc < 20);
        if (tick !== 1'b1) check_eq("tick_timeout", {31'd0, tick}, 1);
    endtask

    // Expected led appears on the cycle after each tick pulse is seen.
    task automatic run_ticks(input string tag, input int n, input int first_gap);
        int cyc;
        for (int k = 0; k < n; k++) begin
            wait_tick(cyc);
            check_eq($sformatf("%s_gap%0d", tag, k), cyc, (k == 0) ? first_gap : 3);
            @(negedge clk);
            pop_check($sformatf("%s_led%0d", tag, k));
        end
    endtask

    task automatic set_mode(input string tag, input logic [1:0] m, input logic [N-1:0] p,
                            input logic [N-1:0] reload);
        mode    = m;
        pattern = p;
        exp_q.push_back(reload);
        @(negedge clk);
        pop_check({tag, "_reload"});
    endtask

    initial begin
        int cyc;
        int highs;
        rst_n = 1'b0; en = 1'b0; mode = 2'd0; pattern = 4'b1010; bright = 4'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_led", {28'd0, led}, 0);
        check_eq("rst_tick", {31'd0, tick}, 0);
        rst_n = 1'b1;
        exp_q.push_back(4'b1010);
        @(negedge clk);
        pop_check("static_release");

`ifdef LED_PWM_EN
        pattern = 4'b1111; bright = 4'd4;
        repeat (2) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            check_eq("pwm_level", {31'd0, (led == 4'b0000 || led == 4'b1111)}, 1);
            if (led == 4'b1111) highs++;
            @(negedge clk);
        end
        check_eq("pwm_b4_duty", highs, 8);
        bright = 4'd0;
        @(negedge clk);
        highs = 0;
        for (int i = 0; i < 32; i++) begin
            if (led != 4'b0000) highs++;
            @(negedge clk);
        end
        check_eq("pwm_b0_dark", highs, 0);
`else
        pattern = 4'b0110;
        exp_q.push_back(4'b0110);
        @(negedge clk);
        pop_check("static_edit");

        en = 1'b1;
        set_mode("blink", 2'd1, 4'b1010, 4'b1010);
        exp_q.push_back(4'b0000);
        exp_q.push_back(4'b1010);
        run_ticks("blink", 2, 4);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("freeze_tick", {31'd0, tick}, 0);
            check_eq("freeze_led", {28'd0, led}, 4'b1010);
        end
        en = 1'b1;
        exp_q.push_back(4'b0000);
        run_ticks("blink_resume", 1, 3);

        set_mode("rot", 2'd2, 4'b0001, 4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        run_ticks("rot", 2, 4);
        pattern = 4'b1111;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001);
        run_ticks("rot_edit", 2, 3);

        set_mode("bounce", 2'd3, 4'b0000, 4'b0001);
        foreach (exp_q[i]) begin end
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        run_ticks("bounce", 7, 4);

        wait_tick(cyc);
        check_eq("coin_gap", cyc, 3);
        set_mode("coin", 2'd2, 4'b1000, 4'b1000);
        exp_q.push_back(4'b0001);
        run_ticks("coin", 1, 4);

        set_mode("rstmid", 2'd3, 4'b0000, 4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0100);
        run_ticks("rstmid", 2, 4);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", {28'd0, led}, 0);
        check_eq("async_rst_tick", {31'd0, tick}, 0);
        @(negedge clk);
        check_eq("hold_rst_led", {28'd0, led}, 0);
        rst_n = 1'b1;
        exp_q.push_back(4'b0001);
        @(negedge clk);
        pop_check("post_rst_reload");
        exp_q.push_back(4'b0010);
        run_ticks("post_rst", 1, 4);

        set_mode("bright0", 2'd0, 4'b1111, 4'b1111);
        exp_q.push_back(4'b1111);
        @(negedge clk);
        pop_check("bright0_hold");
`endif

        check_eq("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
